// File: rtl/capture_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// capture_sweep_ctrl_pkg
// Shared definitions for the capture sweep sequencer: state encoding, data and
// count widths, the default sweep depth, and the byte-level req/ack constants
// that the I2C EEPROM writer uses on its side of the handshake.
// -----------------------------------------------------------------------------
package capture_sweep_ctrl_pkg;

    // Width of one captured sample and of one byte handed to the EEPROM writer.
    localparam int DATA_W = 8;

    // Width of the byte counter. It must hold DEPTH itself, because it never
    // wraps and stops at exactly DEPTH.
    localparam int COUNT_W = 9;

    // Samples per sweep. Must equal the capture buffer's fill count.
    localparam int DEFAULT_DEPTH = 256;

    // Byte handshake with the I2C EEPROM writer. The writer samples i2c_data
    // while i2c_req is at I2C_REQ_ASSERT and answers with I2C_ACK_ACCEPT for
    // exactly the cycle in which it takes the byte.
    localparam logic I2C_REQ_ASSERT = 1'b1;
    localparam logic I2C_ACK_ACCEPT = 1'b1;

    // Sweep sequencer states (4-bit encoding).
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,  // waiting for start
        ST_ARM      = 4'd1,  // enable the buffer for one cycle
        ST_FILL     = 4'd2,  // waiting for the next ADC sample
        ST_WGAP     = 4'd3,  // mandatory idle gap after a buffer write
        ST_FULLWAIT = 4'd4,  // waiting for the buffer to report full
        ST_RSTB     = 4'd5,  // buffer read strobe
        ST_RLAT     = 4'd6,  // buffer read latency
        ST_SEND     = 4'd7,  // byte offered to the EEPROM writer
        ST_FIN      = 4'd8   // sweep complete, done pulse
    } state_t;

    // Largest of three delay settings; sizes the shared delay counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/capture_sweep_ctrl_cycle_delay_counter.sv
// -----------------------------------------------------------------------------
// cycle_delay_counter
// Loadable down-counter shared by the write gap, the read latency and the
// full-flag timeout of the capture sweep sequencer. Loading value N makes
// 'expired' rise N cycles later; the counter then rests at zero until the next
// load, so 'expired' stays high while it is idle.
// -----------------------------------------------------------------------------
module cycle_delay_counter
    import capture_sweep_ctrl_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    // Count down from the loaded value and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state always uses non-blocking '<=' so every register
        // samples the pre-edge values of its neighbours, whatever the order of
        // the statements or of the always blocks.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/capture_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// capture_sweep_ctrl
// Owns the 8-bit capture buffer and shares it between the ADC sample stream and
// the I2C EEPROM writer. One sweep writes DEPTH samples into the buffer, waits
// for the buffer to report full, then reads each byte back and offers it to the
// EEPROM writer under a req/ack handshake.
//
// WR_GAP and RD_LAT must both be at least 1: the buffer advances its internal
// state on the falling edge and needs two cycles between write strobes, and the
// read path always has at least one cycle of latency.
// -----------------------------------------------------------------------------
module capture_sweep_ctrl
    import capture_sweep_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WR_GAP   = 2,
    parameter int RD_LAT   = 2,
    parameter int FULL_TMO = 16
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               start,
    input  logic               adc_valid,
    input  logic [DATA_W-1:0]  adc_data,

    output logic               mem_en,
    output logic               mem_write_en,
    output logic [DATA_W-1:0]  mem_data_in,
    input  logic               mem_is_full,
    output logic               mem_read_en,
    input  logic [DATA_W-1:0]  mem_data_out,

    output logic               i2c_req,
    output logic [DATA_W-1:0]  i2c_data,
    input  logic               i2c_ack,

    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] count
);

    // Shared delay counter sizing and the per-phase load values. A load of
    // N-1 on the edge entering a phase keeps the sequencer in that phase for
    // exactly N cycles, leaving on the cycle the counter reads zero.
    localparam int DLY_MAX = max3(WR_GAP, RD_LAT, FULL_TMO);
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [DLY_W-1:0]   WGAP_LOAD = DLY_W'(WR_GAP - 1);
    localparam logic [DLY_W-1:0]   RLAT_LOAD = DLY_W'(RD_LAT - 1);
    localparam logic [DLY_W-1:0]   TMO_LOAD  = DLY_W'(FULL_TMO - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(DEPTH);

    state_t             state_q;
    state_t             state_d;

    logic               dly_load;
    logic [DLY_W-1:0]   dly_val;
    logic               dly_expired;

    logic [COUNT_W-1:0] count_q;
    logic               wr_stb_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [DATA_W-1:0]  i2c_data_q;
    logic               error_q;

    // Qualified events, decoded once and shared by the FSM and the datapath.
    logic sweep_start;   // start accepted (only while idle)
    logic sample_take;   // ADC sample accepted in FILL
    logic fill_done;     // last write gap finished with DEPTH samples stored
    logic full_seen;     // buffer reports full while we wait for it
    logic full_tmo;      // full flag did not arrive within FULL_TMO cycles
    logic byte_ready;    // read latency elapsed, buffer output is valid
    logic byte_acked;    // EEPROM writer took the offered byte
    logic last_byte;     // the byte being acked is the final one of the sweep

    assign sweep_start = (state_q == ST_IDLE) && start;
    assign sample_take = (state_q == ST_FILL) && adc_valid;
    assign fill_done   = (state_q == ST_WGAP) && dly_expired && (count_q == DEPTH_C);
    assign full_seen   = (state_q == ST_FULLWAIT) && mem_is_full;
    assign full_tmo    = (state_q == ST_FULLWAIT) && !mem_is_full && dly_expired;
    assign byte_ready  = (state_q == ST_RLAT) && dly_expired;
    assign byte_acked  = (state_q == ST_SEND) && (i2c_ack == I2C_ACK_ACCEPT);
    assign last_byte   = ((count_q + COUNT_W'(1)) == DEPTH_C);

    // One counter serves all timed phases; they never overlap, so the load
    // comes from whichever transition enters a timed phase.
    cycle_delay_counter #(
        .W (DLY_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .expired  (dly_expired)
    );

    // Select the delay counter load for the phase being entered.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        dly_load = 1'b0;
        dly_val  = '0;
        if (sample_take) begin
            dly_load = 1'b1;
            dly_val  = WGAP_LOAD;
        end else if (fill_done) begin
            dly_load = 1'b1;
            dly_val  = TMO_LOAD;
        end else if (state_q == ST_RSTB) begin
            dly_load = 1'b1;
            dly_val  = RLAT_LOAD;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start)       state_d = ST_ARM;
            ST_ARM:                       state_d = ST_FILL;
            ST_FILL:     if (adc_valid)   state_d = ST_WGAP;
            ST_WGAP: begin
                if (dly_expired) begin
                    state_d = (count_q == DEPTH_C) ? ST_FULLWAIT : ST_FILL;
                end
            end
            ST_FULLWAIT: begin
                if (mem_is_full) begin
                    state_d = ST_RSTB;
                end else if (dly_expired) begin
                    state_d = ST_FIN;
                end
            end
            ST_RSTB:                      state_d = ST_RLAT;
            ST_RLAT:     if (dly_expired) state_d = ST_SEND;
            ST_SEND: begin
                if (i2c_ack == I2C_ACK_ACCEPT) begin
                    state_d = last_byte ? ST_FIN : ST_RSTB;
                end
            end
            ST_FIN:                       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Datapath: byte counter, registered write strobe/data, outgoing I2C
    // byte and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_stb_q   <= 1'b0;
            wr_data_q  <= '0;
            i2c_data_q <= '0;
            error_q    <= 1'b0;
        end else begin
            // The write strobe follows the accepting FILL cycle and lasts one
            // cycle; the WGAP that follows keeps the next one WR_GAP+1 away.
            wr_stb_q <= sample_take;
            if (sample_take) begin
                wr_data_q <= adc_data;
            end

            // Counts writes during fill, restarts at zero for the drain.
            if (sweep_start || full_seen) begin
                count_q <= '0;
            end else if (sample_take || byte_acked) begin
                count_q <= count_q + COUNT_W'(1);
            end

            // Held stable for the whole SEND phase.
            if (byte_ready) begin
                i2c_data_q <= mem_data_out;
            end

            if (sweep_start) begin
                error_q <= 1'b0;
            end else if (full_tmo) begin
                error_q <= 1'b1;
            end
        end
    end

    // Output decode from the current state and the datapath registers.
    always_comb begin
        mem_en       = (state_q == ST_ARM);
        mem_write_en = wr_stb_q;
        mem_data_in  = wr_data_q;
        mem_read_en  = (state_q == ST_RSTB);
        i2c_req      = (state_q == ST_SEND) ? I2C_REQ_ASSERT : ~I2C_REQ_ASSERT;
        i2c_data     = i2c_data_q;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_FIN);
        error        = error_q;
        count        = count_q;
    end

endmodule

// File: doc/capture_sweep_ctrl.md
# capture_sweep_ctrl

Sequencer that owns the 8-bit capture buffer (`mem_en` / `write_en` / `read_en` / `is_full` port set) and shares it between two requesters: the ADC sample stream (producer) and the I2C EEPROM writer (consumer). A single sweep fills the buffer with exactly `DEPTH` ADC samples, waits for `is_full`, then reads every byte out and hands it to the I2C writer under a req/ack handshake. It sits between the ADC front end, the buffer and the I2C master in the top level.

## Interface
- `DEPTH`, 256 — samples per sweep; must equal the buffer's fill count.
- `WR_GAP`, 2 — idle cycles enforced after each buffer write strobe.
- `RD_LAT`, 2 — cycles from the `mem_read_en` strobe to valid `mem_data_out`.
- `FULL_TMO`, 16 — cycles to wait for `mem_is_full` before flagging an error.

Ports:
- `clk` in 1 — system clock; all logic on posedge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — one-cycle pulse; begins a sweep when idle.
- `adc_valid` in 1 — ADC sample strobe.
- `adc_data` in 8 — ADC sample.
- `mem_en` out 1 — buffer enable.
- `mem_write_en` out 1 — buffer write strobe.
- `mem_data_in` out 8 — byte to buffer.
- `mem_is_full` in 1 — buffer full flag.
- `mem_read_en` out 1 — buffer read strobe.
- `mem_data_out` in 8 — byte from buffer.
- `i2c_req` out 1 — byte available for the EEPROM writer.
- `i2c_data` out 8 — byte to the EEPROM writer.
- `i2c_ack` in 1 — writer accepted the byte.
- `busy` out 1 — sweep in progress.
- `done` out 1 — one-cycle pulse when a sweep completes.
- `error` out 1 — sticky; full-timeout occurred.
- `count` out 9 — bytes written (fill phase) or bytes sent (drain phase).

## Operation
- States: IDLE, ARM, FILL, WGAP, FULLWAIT, RSTB, RLAT, SEND, FIN.
- IDLE: all strobes low, `busy`=0. `start` -> ARM, clears `count`.
- ARM: `mem_en`=1 for one cycle -> FILL.
- FILL: on `adc_valid`, drive `mem_data_in`=`adc_data` and `mem_write_en`=1 for exactly one cycle, increment `count`, then -> WGAP. ADC strobes that arrive outside FILL are dropped; they are never queued.
- WGAP: wait `WR_GAP` cycles. If `count`==`DEPTH` -> FULLWAIT; else -> FILL.
- FULLWAIT: on `mem_is_full`=1, clear `count` and go -> RSTB. If `FULL_TMO` cycles elapse without it, set `error` -> FIN.
- RSTB: `mem_read_en`=1 for one cycle -> RLAT.
- RLAT: wait `RD_LAT` cycles, latch `mem_data_out` into `i2c_data`, then -> SEND.
- SEND: hold `i2c_req`=1 with `i2c_data` stable until `i2c_ack`=1. On that cycle, drop `i2c_req` and increment `count`. If `count`+1==`DEPTH` -> FIN; else -> RSTB.
- FIN: pulse `done` for one cycle -> IDLE. `error` stays set until the next `start`.
- `start` is ignored while `busy`=1.
- `count` is 9-bit unsigned with no wrap; it reaches exactly `DEPTH`.

## Timing
- Reset values: all outputs 0, `count`=0, state IDLE. Reset mid-sweep aborts immediately with no `done`.
- `start` to `mem_en`: 1 cycle. `mem_en` to first eligible write: 1 cycle.
- Minimum write spacing: `WR_GAP`+1 cycles. The buffer needs ≥2 (its internal state advances on negedge), so `WR_GAP` < 1 is illegal.
- Read byte N: `mem_read_en` at cycle t, `i2c_req` rises at t+`RD_LAT`+1.
- `busy`=1 from the cycle after `start` through FIN inclusive.
- `i2c_ack` while `i2c_req`=0 is ignored.
- `adc_valid` and `start` in the same cycle: the sample is ignored.

## Structure
- Shared package holds the state encoding (4-bit), the default `DEPTH`, and the I2C byte-handshake constants shared with the EEPROM writer.
- Split out one sub-module: `cycle_delay_counter`, a loadable down-counter used by WGAP, RLAT and FULLWAIT.

## Test plan
- Nominal sweep, `DEPTH`=4, ADC sends 0x11,0x22,0x33,0x44 with immediate ack -> exactly 4 write strobes, then `i2c_data` sequence 0x11..0x44, one `done`, `error`=0.
- Back-to-back `adc_valid` every cycle -> only one sample accepted per `WR_GAP`+1 cycles; `count`=4 after 4 accepted samples.
- Ack delayed 10 cycles on byte 2 -> `i2c_req` and `i2c_data` held stable for all 10 cycles, no extra `mem_read_en`.
- `mem_is_full` never asserted -> `error`=1 after 16 cycles, `done` pulse, no `mem_read_en`.
- `rst_n` low during SEND -> all outputs 0 asynchronously; a subsequent `start` runs a clean sweep.
- `start` pulsed while busy -> no restart, and `count` is undisturbed.
